// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and defaults for the two-port data memory arbiter.
package data_mem_arbiter_pkg;

  // Default geometry of the shared dataMemory instance.
  localparam int DEFAULT_MEM_ADDR_W = 5;
  localparam int DEFAULT_MEM_DATA_W = 32;

  // Arbiter FSM states. The LOCK states hold ownership for an atomic sequence.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_LOCK_A = 2'd1,
    ARB_LOCK_B = 2'd2
  } arb_state_e;

  // Port that received the most recent grant. Used to break ties.
  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_e;

endpackage : data_mem_arbiter_pkg

// File: rtl/arb_rr2.sv
// Two-way round-robin pick. Purely combinational.
// While a port holds the lock, only that port can be picked.
module arb_rr2
  import data_mem_arbiter_pkg::*;
(
  input  logic       a_req,
  input  logic       b_req,
  input  owner_e     last_owner,
  input  arb_state_e state,
  output logic       a_pick,
  output logic       b_pick
);

  // Select at most one requester from the lock state and the last owner.
  always_comb begin
    a_pick = 1'b0;
    b_pick = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (a_req && b_req) begin
          if (last_owner == OWNER_B) begin
            a_pick = 1'b1;
            b_pick = 1'b0;
          end else begin
            a_pick = 1'b0;
            b_pick = 1'b1;
          end
        end else begin
          a_pick = a_req;
          b_pick = b_req;
        end
      end
      ARB_LOCK_A: begin
        a_pick = a_req;
        b_pick = 1'b0;
      end
      ARB_LOCK_B: begin
        a_pick = 1'b0;
        b_pick = b_req;
      end
      default: begin
        a_pick = 1'b0;
        b_pick = 1'b0;
      end
    endcase
  end

endmodule : arb_rr2

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter that shares one dataMemory between the core LSU (port A)
// and a debug/DMA loader (port B). Grants and memory controls are combinational.
// Read data and the read-valid strobe are registered per port. A port can keep
// ownership for up to MAX_LOCK consecutive grants to do atomic read-modify-write.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_MEM_ADDR_W,
  parameter int DATA_WIDTH = DEFAULT_MEM_DATA_W,
  parameter int MAX_LOCK   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  aReq,
  input  logic                  aWe,
  input  logic                  aLock,
  input  logic [ADDR_WIDTH-1:0] aAddr,
  input  logic [DATA_WIDTH-1:0] aWdata,
  input  logic                  bReq,
  input  logic                  bWe,
  input  logic                  bLock,
  input  logic [ADDR_WIDTH-1:0] bAddr,
  input  logic [DATA_WIDTH-1:0] bWdata,
  output logic                  aGnt,
  output logic                  bGnt,
  output logic                  aRvalid,
  output logic                  bRvalid,
  output logic [DATA_WIDTH-1:0] aRdata,
  output logic [DATA_WIDTH-1:0] bRdata,
  output logic                  memRead,
  output logic                  memWrite,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic [DATA_WIDTH-1:0] memWriteData,
  input  logic [DATA_WIDTH-1:0] memReadData
);

  localparam int CNT_W = (MAX_LOCK < 1) ? 1 : $clog2(MAX_LOCK + 1);

  arb_state_e            state_q,      state_d;
  owner_e                last_owner_q, last_owner_d;
  logic [CNT_W-1:0]      lock_cnt_q,   lock_cnt_d;
  logic                  a_rvalid_q,   a_rvalid_d;
  logic                  b_rvalid_q,   b_rvalid_d;
  logic [DATA_WIDTH-1:0] a_rdata_q,    a_rdata_d;
  logic [DATA_WIDTH-1:0] b_rdata_q,    b_rdata_d;

  logic a_pick_s;
  logic b_pick_s;
  logic a_gnt_s;
  logic b_gnt_s;
  logic lock_full_s;

  arb_rr2 u_arb_rr2 (
    .a_req      (aReq),
    .b_req      (bReq),
    .last_owner (last_owner_q),
    .state      (state_q),
    .a_pick     (a_pick_s),
    .b_pick     (b_pick_s)
  );

  // Nothing reaches the memory or the requesters while reset is held.
  assign a_gnt_s = a_pick_s & rst_n;
  assign b_gnt_s = b_pick_s & rst_n;

  // True when the grant in progress is the last one the lock budget allows.
  assign lock_full_s = (int'(lock_cnt_q) + 32'sd1) >= MAX_LOCK;

  // Steer the winning port onto the memory interface; idle when nobody wins.
  always_comb begin
    memRead      = 1'b0;
    memWrite     = 1'b0;
    memAddress   = '0;
    memWriteData = '0;
    if (a_gnt_s) begin
      memRead      = ~aWe;
      memWrite     = aWe;
      memAddress   = aAddr;
      memWriteData = aWdata;
    end else if (b_gnt_s) begin
      memRead      = ~bWe;
      memWrite     = bWe;
      memAddress   = bAddr;
      memWriteData = bWdata;
    end else begin
      memRead      = 1'b0;
      memWrite     = 1'b0;
      memAddress   = '0;
      memWriteData = '0;
    end
  end

  // Lock FSM, lock budget counter and round-robin history.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    lock_cnt_d   = lock_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (a_pick_s) begin
          last_owner_d = OWNER_A;
          if (aLock && !lock_full_s) begin
            state_d    = ARB_LOCK_A;
            lock_cnt_d = CNT_W'(1);
          end else begin
            state_d    = ARB_IDLE;
            lock_cnt_d = '0;
          end
        end else if (b_pick_s) begin
          last_owner_d = OWNER_B;
          if (bLock && !lock_full_s) begin
            state_d    = ARB_LOCK_B;
            lock_cnt_d = CNT_W'(1);
          end else begin
            state_d    = ARB_IDLE;
            lock_cnt_d = '0;
          end
        end else begin
          state_d    = ARB_IDLE;
          lock_cnt_d = '0;
        end
      end
      ARB_LOCK_A: begin
        if (!a_pick_s) begin
          // Owner walked away: release without granting anyone this cycle.
          state_d    = ARB_IDLE;
          lock_cnt_d = '0;
        end else begin
          last_owner_d = OWNER_A;
          if (aLock && !lock_full_s) begin
            state_d    = ARB_LOCK_A;
            lock_cnt_d = lock_cnt_q + CNT_W'(1);
          end else begin
            state_d    = ARB_IDLE;
            lock_cnt_d = '0;
          end
        end
      end
      ARB_LOCK_B: begin
        if (!b_pick_s) begin
          state_d    = ARB_IDLE;
          lock_cnt_d = '0;
        end else begin
          last_owner_d = OWNER_B;
          if (bLock && !lock_full_s) begin
            state_d    = ARB_LOCK_B;
            lock_cnt_d = lock_cnt_q + CNT_W'(1);
          end else begin
            state_d    = ARB_IDLE;
            lock_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d      = ARB_IDLE;
        last_owner_d = last_owner_q;
        lock_cnt_d   = '0;
      end
    endcase
  end

  // Capture read data on a read grant; otherwise hold the previous value.
  always_comb begin
    a_rvalid_d = a_pick_s & ~aWe;
    b_rvalid_d = b_pick_s & ~bWe;
    if (a_rvalid_d) begin
      a_rdata_d = memReadData;
    end else begin
      a_rdata_d = a_rdata_q;
    end
    if (b_rvalid_d) begin
      b_rdata_d = memReadData;
    end else begin
      b_rdata_d = b_rdata_q;
    end
  end

  // State and response registers; reset drops any read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      last_owner_q <= OWNER_B;
      lock_cnt_q   <= '0;
      a_rvalid_q   <= 1'b0;
      b_rvalid_q   <= 1'b0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      lock_cnt_q   <= lock_cnt_d;
      a_rvalid_q   <= a_rvalid_d;
      b_rvalid_q   <= b_rvalid_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
    end
  end

  assign aGnt    = a_gnt_s;
  assign bGnt    = b_gnt_s;
  assign aRvalid = a_rvalid_q;
  assign bRvalid = b_rvalid_q;
  assign aRdata  = a_rdata_q;
  assign bRdata  = b_rdata_q;

endmodule : data_mem_arbiter

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus a randomized run checked
// against a behavioural model of the arbitration rules and a reference memory.
module tb_data_mem_arbiter;

  localparam int AW       = 5;
  localparam int DW       = 32;
  localparam int MAX_LOCK = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          aReq = 1'b0, aWe = 1'b0, aLock = 1'b0;
  logic [AW-1:0] aAddr = '0;
  logic [DW-1:0] aWdata = '0;
  logic          bReq = 1'b0, bWe = 1'b0, bLock = 1'b0;
  logic [AW-1:0] bAddr = '0;
  logic [DW-1:0] bWdata = '0;
  logic          aGnt, bGnt, aRvalid, bRvalid;
  logic [DW-1:0] aRdata, bRdata;
  logic          memRead, memWrite;
  logic [AW-1:0] memAddress;
  logic [DW-1:0] memWriteData, memReadData;

  int checks = 0;
  int errors = 0;

  // Stand-in for the external dataMemory: combinational read, write on posedge.
  logic [DW-1:0] dmem [0:(1<<AW)-1];
  // Reference memory, updated by the bench model only.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  assign memReadData = dmem[memAddress];

  always @(posedge clk) begin
    if (memWrite) dmem[memAddress] <= memWriteData;
  end

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .rst_n(rst_n),
    .aReq(aReq), .aWe(aWe), .aLock(aLock), .aAddr(aAddr), .aWdata(aWdata),
    .bReq(bReq), .bWe(bWe), .bLock(bLock), .bAddr(bAddr), .bWdata(bWdata),
    .aGnt(aGnt), .bGnt(bGnt), .aRvalid(aRvalid), .bRvalid(bRvalid),
    .aRdata(aRdata), .bRdata(bRdata),
    .memRead(memRead), .memWrite(memWrite), .memAddress(memAddress),
    .memWriteData(memWriteData), .memReadData(memReadData)
  );

  task automatic set_a(input logic req, input logic we, input logic lk,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    aReq = req; aWe = we; aLock = lk; aAddr = addr; aWdata = wd;
  endtask

  task automatic set_b(input logic req, input logic we, input logic lk,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    bReq = req; bWe = we; bLock = lk; bAddr = addr; bWdata = wd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_a(1'b0, 1'b0, 1'b0, '0, '0);
    set_b(1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    set_a(1'b1, 1'b1, 1'b0, 5'h01, 32'h1);
    set_b(1'b1, 1'b0, 1'b0, 5'h02, 32'h2);
    #1;
    checks++;
    if ({aGnt, bGnt, memRead, memWrite} !== 4'b0000) begin
      errors++; $display("FAIL reset_gnt: got %b expected 0000", {aGnt, bGnt, memRead, memWrite});
    end
    @(posedge clk); #1;
    checks++;
    if ({aRvalid, bRvalid} !== 2'b00 || aRdata !== 32'h0 || bRdata !== 32'h0) begin
      errors++; $display("FAIL reset_resp: got rv=%b ard=%h brd=%h expected 0", {aRvalid, bRvalid}, aRdata, bRdata);
    end
    @(negedge clk);
    set_a(1'b0, 1'b0, 1'b0, '0, '0);
    set_b(1'b0, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    set_a(1'b1, 1'b1, 1'b0, 5'h03, 32'hDEADBEEF);
    #1;
    checks++;
    if (aGnt !== 1'b1 || memWrite !== 1'b1 || memRead !== 1'b0 || memAddress !== 5'h03 || memWriteData !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_grant: got gnt=%b we=%b re=%b addr=%h wd=%h expected 1 1 0 03 deadbeef", aGnt, memWrite, memRead, memAddress, memWriteData);
    end
    @(posedge clk); #1;
    checks++;
    if (aRvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid: got %b expected 0", aRvalid); end
    @(negedge clk);
    set_a(1'b1, 1'b0, 1'b0, 5'h03, 32'h0);
    #1;
    checks++;
    if (aGnt !== 1'b1 || memRead !== 1'b1 || memWrite !== 1'b0) begin
      errors++; $display("FAIL rd_grant: got gnt=%b re=%b we=%b expected 1 1 0", aGnt, memRead, memWrite);
    end
    @(posedge clk); #1;
    checks++;
    if (aRvalid !== 1'b1 || aRdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd_data: got rv=%b data=%h expected 1 deadbeef", aRvalid, aRdata);
    end
    @(negedge clk);
    set_a(1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    checks++;
    if (aRvalid !== 1'b0 || aRdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd_hold: got rv=%b data=%h expected 0 deadbeef", aRvalid, aRdata);
    end
  endtask

  task automatic test_tie_alternation();
    logic [3:0] exp_a;
    exp_a = 4'b0101;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_a(1'b1, 1'b0, 1'b0, 5'(i), '0);
      set_b(1'b1, 1'b0, 1'b0, 5'(i + 8), '0);
      #1;
      checks++;
      if (aGnt !== exp_a[i] || bGnt !== ~exp_a[i]) begin
        errors++; $display("FAIL tie_%0d: got a=%b b=%b expected a=%b b=%b", i, aGnt, bGnt, exp_a[i], ~exp_a[i]);
      end
      @(posedge clk);
    end
    @(negedge clk);
    set_a(1'b0, 1'b0, 1'b0, '0, '0);
    set_b(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_locked_rmw();
    do_reset();
    @(negedge clk);
    set_a(1'b1, 1'b1, 1'b0, 5'h10, 32'h11111111);
    @(posedge clk);
    @(negedge clk);
    set_a(1'b1, 1'b0, 1'b0, 5'h10, '0);
    set_b(1'b1, 1'b0, 1'b1, 5'h10, '0);
    #1;
    checks++;
    if (aGnt !== 1'b0 || bGnt !== 1'b1) begin
      errors++; $display("FAIL rmw_read: got a=%b b=%b expected a=0 b=1", aGnt, bGnt);
    end
    @(posedge clk); #1;
    checks++;
    if (bRvalid !== 1'b1 || bRdata !== 32'h11111111) begin
      errors++; $display("FAIL rmw_rdata: got rv=%b data=%h expected 1 11111111", bRvalid, bRdata);
    end
    @(negedge clk);
    set_b(1'b1, 1'b1, 1'b0, 5'h10, 32'hCAFE0001);
    #1;
    checks++;
    if (aGnt !== 1'b0 || bGnt !== 1'b1) begin
      errors++; $display("FAIL rmw_write: got a=%b b=%b expected a=0 b=1", aGnt, bGnt);
    end
    @(posedge clk);
    @(negedge clk);
    set_b(1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    checks++;
    if (aGnt !== 1'b1) begin errors++; $display("FAIL rmw_a_after: got %b expected 1", aGnt); end
    @(posedge clk); #1;
    checks++;
    if (aRvalid !== 1'b1 || aRdata !== 32'hCAFE0001) begin
      errors++; $display("FAIL rmw_result: got rv=%b data=%h expected 1 cafe0001", aRvalid, aRdata);
    end
    @(negedge clk);
    set_a(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_lock_limit();
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    exp_a = 8'b0010_1111;
    exp_b = 8'b1001_0000;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_a(i < 6, 1'b0, 1'b1, 5'(i), '0);
      set_b((i < 5) || (i >= 6), 1'b0, 1'b0, 5'h1F, '0);
      #1;
      checks++;
      if (aGnt !== exp_a[i] || bGnt !== exp_b[i]) begin
        errors++; $display("FAIL lock_limit_%0d: got a=%b b=%b expected a=%b b=%b", i, aGnt, bGnt, exp_a[i], exp_b[i]);
      end
      @(posedge clk);
    end
    @(negedge clk);
    set_a(1'b0, 1'b0, 1'b0, '0, '0);
    set_b(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset_in_flight();
    do_reset();
    @(negedge clk);
    set_a(1'b1, 1'b0, 1'b0, 5'h03, '0);
    #1;
    checks++;
    if (aGnt !== 1'b1) begin errors++; $display("FAIL rif_grant: got %b expected 1", aGnt); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    set_a(1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    checks++;
    if (aRvalid !== 1'b0 || aRdata !== 32'h0) begin
      errors++; $display("FAIL rif_drop: got rv=%b data=%h expected 0 0", aRvalid, aRdata);
    end
    @(posedge clk); #1;
    checks++;
    if (aRvalid !== 1'b0) begin errors++; $display("FAIL rif_rvalid: got %b expected 0", aRvalid); end
    @(negedge clk);
    rst_n = 1'b1;
    set_a(1'b1, 1'b0, 1'b0, 5'h04, '0);
    set_b(1'b1, 1'b0, 1'b0, 5'h05, '0);
    #1;
    checks++;
    if (aGnt !== 1'b1 || bGnt !== 1'b0) begin
      errors++; $display("FAIL rif_tie: got a=%b b=%b expected a=1 b=0", aGnt, bGnt);
    end
    @(posedge clk);
    @(negedge clk);
    set_a(1'b0, 1'b0, 1'b0, '0, '0);
    set_b(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_random();
    logic          pa, pb, pa_we, pb_we, pa_lk, pb_lk;
    logic [AW-1:0] pa_addr, pb_addr, eaddr;
    logic [DW-1:0] pa_wd, pb_wd, ewd, exp_rd_a, exp_rd_b;
    logic          ea, eb, erd, ewr, exp_rv_a, exp_rv_b;
    int            wa, wb, holder, left, last_won;

    do_reset();
    // Fill the whole memory through port A so the model knows every word.
    for (int i = 0; i < (1 << AW); i++) begin
      @(negedge clk);
      ref_mem[i] = $urandom;
      set_a(1'b1, 1'b1, 1'b0, 5'(i), ref_mem[i]);
      #1;
      checks++;
      if (aGnt !== 1'b1) begin errors++; $display("FAIL preload_%0d: got %b expected 1", i, aGnt); end
      @(posedge clk);
    end
    // Model: holder 0 = nobody, 1 = A, 2 = B; left = locked grants still allowed.
    holder = 0; left = 0; last_won = 1;
    pa = 1'b0; pb = 1'b0; wa = 0; wb = 0;
    pa_we = 1'b0; pb_we = 1'b0; pa_lk = 1'b0; pb_lk = 1'b0;
    pa_addr = '0; pb_addr = '0; pa_wd = '0; pb_wd = '0;
    exp_rd_a = 32'h0; exp_rd_b = 32'h0;

    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      if (!pa && $urandom_range(0, 9) < 6) begin
        pa = 1'b1; pa_we = 1'($urandom_range(0, 1)); pa_lk = ($urandom_range(0, 2) != 0);
        pa_addr = 5'($urandom_range(0, 31)); pa_wd = $urandom;
      end
      if (!pb && $urandom_range(0, 9) < 6) begin
        pb = 1'b1; pb_we = 1'($urandom_range(0, 1)); pb_lk = ($urandom_range(0, 2) != 0);
        pb_addr = 5'($urandom_range(0, 31)); pb_wd = $urandom;
      end
      set_a(pa, pa_we, pa_lk, pa_addr, pa_wd);
      set_b(pb, pb_we, pb_lk, pb_addr, pb_wd);
      #1;
      if (holder == 1) begin
        ea = pa; eb = 1'b0;
      end else if (holder == 2) begin
        ea = 1'b0; eb = pb;
      end else if (pa && pb) begin
        ea = (last_won == 2); eb = !ea;
      end else begin
        ea = pa; eb = pb;
      end
      checks++;
      if (aGnt !== ea || bGnt !== eb) begin
        errors++; $display("FAIL rnd_gnt cyc %0d: got a=%b b=%b expected a=%b b=%b", cyc, aGnt, bGnt, ea, eb);
      end
      if (ea) begin
        erd = ~pa_we; ewr = pa_we; eaddr = pa_addr; ewd = pa_wd;
      end else if (eb) begin
        erd = ~pb_we; ewr = pb_we; eaddr = pb_addr; ewd = pb_wd;
      end else begin
        erd = 1'b0; ewr = 1'b0; eaddr = '0; ewd = '0;
      end
      checks++;
      if ({memRead, memWrite, memAddress, memWriteData} !== {erd, ewr, eaddr, ewd}) begin
        errors++; $display("FAIL rnd_mem cyc %0d: got re=%b we=%b addr=%h wd=%h expected %b %b %h %h",
                           cyc, memRead, memWrite, memAddress, memWriteData, erd, ewr, eaddr, ewd);
      end
      exp_rv_a = ea && !pa_we;
      exp_rv_b = eb && !pb_we;
      if (exp_rv_a) exp_rd_a = ref_mem[pa_addr];
      if (exp_rv_b) exp_rd_b = ref_mem[pb_addr];
      if (ea && pa_we) ref_mem[pa_addr] = pa_wd;
      if (eb && pb_we) ref_mem[pb_addr] = pb_wd;
      // Lock bookkeeping from the ownership rules.
      if (holder == 1) begin
        if (!pa) holder = 0;
        else begin
          last_won = 1; left--;
          if (!(pa_lk && left > 0)) holder = 0;
        end
      end else if (holder == 2) begin
        if (!pb) holder = 0;
        else begin
          last_won = 2; left--;
          if (!(pb_lk && left > 0)) holder = 0;
        end
      end else if (ea) begin
        last_won = 1;
        if (pa_lk && MAX_LOCK > 1) begin holder = 1; left = MAX_LOCK - 1; end
      end else if (eb) begin
        last_won = 2;
        if (pb_lk && MAX_LOCK > 1) begin holder = 2; left = MAX_LOCK - 1; end
      end
      if (ea) begin
        pa = 1'b0; wa = 0;
      end else if (pa) begin
        wa++;
        checks++;
        if (wa > MAX_LOCK + 1) begin errors++; $display("FAIL rnd_starve_a cyc %0d: waited %0d limit %0d", cyc, wa, MAX_LOCK + 1); end
      end
      if (eb) begin
        pb = 1'b0; wb = 0;
      end else if (pb) begin
        wb++;
        checks++;
        if (wb > MAX_LOCK + 1) begin errors++; $display("FAIL rnd_starve_b cyc %0d: waited %0d limit %0d", cyc, wb, MAX_LOCK + 1); end
      end
      @(posedge clk); #1;
      checks++;
      if (aRvalid !== exp_rv_a || bRvalid !== exp_rv_b || aRdata !== exp_rd_a || bRdata !== exp_rd_b) begin
        errors++; $display("FAIL rnd_resp cyc %0d: got rv=%b%b ard=%h brd=%h expected rv=%b%b ard=%h brd=%h",
                           cyc, aRvalid, bRvalid, aRdata, bRdata, exp_rv_a, exp_rv_b, exp_rd_a, exp_rd_b);
      end
    end
    @(negedge clk);
    set_a(1'b0, 1'b0, 1'b0, '0, '0);
    set_b(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_tie_alternation();
    test_locked_rmw();
    test_lock_limit();
    test_reset_in_flight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_data_mem_arbiter
